// File: rtl/rpxx_seek_sequencer.sv
// RPxx drive positioning sequencer: seek/search/recalibrate with cylinder stepping,
// head settle and a free-running rotational sector model; emits drive status strobes.
module rpxx_seek_sequencer #(
    parameter int NCYL     = 815,
    parameter int NSECT    = 20,
    parameter int CYL_DLY  = 4,
    parameter int SETTLE   = 8,
    parameter int SECT_DLY = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       rpCD,
    input  logic       cmdSEEK,
    input  logic       cmdSEARCH,
    input  logic       cmdRECAL,
    input  logic [9:0] rpDCA,
    input  logic [4:0] rpDSA,
    output logic [9:0] rpCCA,
    output logic [4:0] rpSEC,
    output logic       setPIP,
    output logic       setDRY,
    output logic       setATA,
    output logic       setIAE,
    output logic       setRMR
);

    // state    | meaning
    // S_IDLE   | ready, accepts commands when media present
    // S_SEEK   | stepping rpCCA toward target, CYL_DLY cycles per cylinder
    // S_SETTLE | head settle after arrival
    // S_SEARCH | waiting for desired sector under the head at phase 0
    // S_DONE   | one-cycle attention, back to idle
    typedef enum logic [2:0] {
        S_IDLE, S_SEEK, S_SETTLE, S_SEARCH, S_DONE
    } state_t;

    localparam int CW = 16;
    localparam int PW = (SECT_DLY > 1) ? $clog2(SECT_DLY) : 1;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [9:0]     cca_q, cca_d;
    logic [9:0]     tgt_q, tgt_d;
    logic [4:0]     dsa_q, dsa_d;
    logic           srch_q, srch_d;
    logic           iae_q, iae_d;
    logic           rmr_q, rmr_d;
    logic [PW-1:0]  phase_q;
    logic [4:0]     sec_q;

    logic any_cmd;
    logic dca_bad;
    logic dsa_bad;

    assign any_cmd = cmdSEEK | cmdSEARCH | cmdRECAL;
    assign dca_bad = {22'd0, rpDCA} >= 32'(NCYL);
    assign dsa_bad = {27'd0, rpDSA} >= 32'(NSECT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cca_q   <= '0;
            tgt_q   <= '0;
            dsa_q   <= '0;
            srch_q  <= 1'b0;
            iae_q   <= 1'b0;
            rmr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cca_q   <= cca_d;
            tgt_q   <= tgt_d;
            dsa_q   <= dsa_d;
            srch_q  <= srch_d;
            iae_q   <= iae_d;
            rmr_q   <= rmr_d;
        end
    end

    // Rotation never stops: the platter spins regardless of positioning activity.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= '0;
            sec_q   <= '0;
        end else if (phase_q == PW'(SECT_DLY - 1)) begin
            phase_q <= '0;
            sec_q   <= (sec_q == 5'(NSECT - 1)) ? 5'd0 : sec_q + 5'd1;
        end else begin
            phase_q <= phase_q + PW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cca_d   = cca_q;
        tgt_d   = tgt_q;
        dsa_d   = dsa_q;
        srch_d  = srch_q;
        iae_d   = 1'b0;
        rmr_d   = 1'b0;

        if (clr) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (state_q != S_IDLE && !rpCD) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_cmd && rpCD) begin
                        cnt_d = '0;
                        dsa_d = rpDSA;
                        if (cmdRECAL) begin
                            tgt_d   = '0;
                            srch_d  = 1'b0;
                            state_d = S_SEEK;
                        end else begin
                            tgt_d  = rpDCA;
                            srch_d = cmdSEARCH;
                            if (dca_bad || (cmdSEARCH && dsa_bad)) begin
                                state_d = S_DONE;
                                iae_d   = 1'b1;
                            end else begin
                                state_d = S_SEEK;
                            end
                        end
                    end
                end
                S_SEEK: begin
                    if (cca_q == tgt_q) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(CYL_DLY - 1)) begin
                        cca_d = (cca_q < tgt_q) ? cca_q + 10'd1 : cca_q - 10'd1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == CW'(SETTLE - 1)) begin
                        cnt_d   = '0;
                        state_d = srch_q ? S_SEARCH : S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_SEARCH: begin
                    if (sec_q == dsa_q && phase_q == '0) state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            if (state_q != S_IDLE && any_cmd) rmr_d = 1'b1;
        end
    end

    assign rpCCA  = cca_q;
    assign rpSEC  = sec_q;
    assign setPIP = (state_q == S_SEEK) || (state_q == S_SETTLE) || (state_q == S_SEARCH);
    assign setDRY = (state_q == S_IDLE) && rpCD;
    assign setATA = (state_q == S_DONE);
    assign setIAE = iae_q;
    assign setRMR = rmr_q;

endmodule

// File: tb/tb_rpxx_seek_sequencer.sv
// Bench for rpxx_seek_sequencer: directed test-plan scenarios then random traffic,
// all checked against a schedule-based model of the drive.
module tb_rpxx_seek_sequencer;

    localparam int NCYL = 815, NSECT = 20, CYL_DLY = 4, SETTLE = 8, SECT_DLY = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       rpCD = 1'b1;
    logic       cmdSEEK = 1'b0, cmdSEARCH = 1'b0, cmdRECAL = 1'b0;
    logic [9:0] rpDCA = '0;
    logic [4:0] rpDSA = '0;
    logic [9:0] rpCCA;
    logic [4:0] rpSEC;
    logic       setPIP, setDRY, setATA, setIAE, setRMR;

    rpxx_seek_sequencer #(
        .NCYL(NCYL), .NSECT(NSECT), .CYL_DLY(CYL_DLY), .SETTLE(SETTLE), .SECT_DLY(SECT_DLY)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .rpCD(rpCD),
        .cmdSEEK(cmdSEEK), .cmdSEARCH(cmdSEARCH), .cmdRECAL(cmdRECAL),
        .rpDCA(rpDCA), .rpDSA(rpDSA), .rpCCA(rpCCA), .rpSEC(rpSEC),
        .setPIP(setPIP), .setDRY(setDRY), .setATA(setATA), .setIAE(setIAE), .setRMR(setRMR)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_tests++;
        if (obs !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: an accepted command is a schedule (start edge, distance, done offset)
    int m_edge = 0, m_t0 = 0, m_done_k = 0, m_start = 0, m_tgt = 0, m_rot = 0, m_cca = 0;
    bit m_busy = 0, e_iae = 0, e_rmr = 0;

    function automatic int cca_at(int k);
        int d, s;
        d = (m_tgt >= m_start) ? m_tgt - m_start : m_start - m_tgt;
        s = k / CYL_DLY;
        if (s > d) s = d;
        return (m_tgt >= m_start) ? m_start + s : m_start - s;
    endfunction

    task automatic model_edge();
        int kp, d, es, r;
        bit any, srch, bad;
        m_edge++;
        e_iae = 0;
        e_rmr = 0;
        if (!rst) begin
            m_rot = 0; m_busy = 0; m_cca = 0;
            return;
        end
        m_rot++;
        any = cmdSEEK | cmdSEARCH | cmdRECAL;
        kp  = m_edge - 1 - m_t0;
        if (m_busy) begin
            if (clr || !rpCD) begin
                m_cca  = cca_at(kp);
                m_busy = 0;
            end else if (any) begin
                e_rmr = 1;
            end
        end else if (any && rpCD && !clr) begin
            m_busy  = 1;
            m_t0    = m_edge;
            m_start = m_cca;
            srch    = cmdSEARCH && !cmdRECAL;
            m_tgt   = cmdRECAL ? 0 : int'(rpDCA);
            bad     = !cmdRECAL && (int'(rpDCA) >= NCYL || (srch && int'(rpDSA) >= NSECT));
            if (bad) begin
                e_iae    = 1;
                m_tgt    = m_start;
                m_done_k = 0;
            end else begin
                d  = (m_tgt >= m_start) ? m_tgt - m_start : m_start - m_tgt;
                es = d * CYL_DLY + SETTLE + 1;
                m_done_k = es;
                if (srch) begin
                    for (int j = es; j < es + SECT_DLY * NSECT + 2; j++) begin
                        r = m_rot + j;
                        if (r % SECT_DLY == 0 && (r / SECT_DLY) % NSECT == int'(rpDSA)) begin
                            m_done_k = j + 1;
                            break;
                        end
                    end
                end
            end
        end
        if (m_busy && (m_edge - m_t0) > m_done_k) begin
            m_busy = 0;
            m_cca  = m_tgt;
        end
    endtask

    task automatic compare();
        int k;
        k = m_edge - m_t0;
        if (m_busy) begin
            chk("pip", setPIP, int'(k < m_done_k));
            chk("ata", setATA, int'(k == m_done_k));
            chk("dry", setDRY, 0);
            chk("cca", rpCCA, cca_at(k));
        end else begin
            chk("pip", setPIP, 0);
            chk("ata", setATA, 0);
            chk("dry", setDRY, int'(rpCD));
            chk("cca", rpCCA, m_cca);
        end
        chk("iae", setIAE, int'(e_iae));
        chk("rmr", setRMR, int'(e_rmr));
        chk("sec", rpSEC, (m_rot / SECT_DLY) % NSECT);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        cmdSEEK = 0; cmdSEARCH = 0; cmdRECAL = 0; clr = 0;
    endtask

    // Steps n edges (first edge samples whatever command is set up) and reports
    // the first edge index showing setATA / setIAE, or -1.
    task automatic run_measure(input int n, output int ata_at, output int iae_at);
        ata_at = -1;
        iae_at = -1;
        for (int j = 0; j < n; j++) begin
            step();
            if (setATA && ata_at < 0) ata_at = j;
            if (setIAE && iae_at < 0) iae_at = j;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 0;
        for (int j = 0; j < n; j++) step();
        rst = 1;
    endtask

    int a, b, rmr_at;

    initial begin
        do_reset(3);
        chk("reset_cca", rpCCA, 0);
        chk("reset_sec", rpSEC, 0);

        // seek d=3 straight after reset
        cmdSEEK = 1; rpDCA = 10'd3;
        run_measure(30, a, b);
        chk("seek3_ata_edge", a, 21);
        chk("seek3_cca", rpCCA, 3);

        // to cylinder 5, then recalibrate
        cmdSEEK = 1; rpDCA = 10'd5;
        run_measure(20, a, b);
        cmdRECAL = 1;
        run_measure(35, a, b);
        chk("recal5_ata_edge", a, 29);
        chk("recal5_cca", rpCCA, 0);

        // search right after reset
        do_reset(2);
        cmdSEARCH = 1; rpDCA = 10'd0; rpDSA = 5'd2;
        run_measure(40, a, b);
        chk("search_ata_edge", a, 32);

        // invalid cylinder
        cmdSEEK = 1; rpDCA = 10'd815;
        run_measure(4, a, b);
        chk("iae_edge", b, 0);
        chk("iae_ata_edge", a, 0);

        // command during active seek
        do_reset(2);
        cmdSEEK = 1; rpDCA = 10'd3;
        rmr_at = -1;
        a = -1;
        for (int j = 0; j < 26; j++) begin
            if (j == 5) begin cmdSEEK = 1; rpDCA = 10'd7; end
            step();
            if (setRMR && rmr_at < 0) rmr_at = j;
            if (setATA && a < 0) a = j;
        end
        chk("rmr_edge", rmr_at, 5);
        chk("rmr_seek_ata_edge", a, 21);

        // SEEK + RECAL together from cylinder 3 -> recal wins
        cmdSEEK = 1; cmdRECAL = 1; rpDCA = 10'd9;
        run_measure(25, a, b);
        chk("prio_ata_edge", a, 3 * CYL_DLY + SETTLE + 1);
        chk("prio_cca", rpCCA, 0);

        // clr at edge 6 of a d=3 seek
        cmdSEEK = 1; rpDCA = 10'd3;
        for (int j = 0; j < 6; j++) step();
        clr = 1;
        step();
        chk("clr_cca", rpCCA, 1);
        run_measure(25, a, b);
        chk("clr_no_ata", a, -1);

        // media drop mid-settle of a d=1 seek
        cmdSEEK = 1; rpDCA = 10'd2;
        for (int j = 0; j < 8; j++) step();
        rpCD = 0;
        step();
        chk("cd_drop_dry", setDRY, 0);
        rpCD = 1;
        run_measure(12, a, b);
        chk("cd_drop_no_ata", a, -1);

        // reset mid-seek
        cmdSEEK = 1; rpDCA = 10'd9;
        for (int j = 0; j < 6; j++) step();
        do_reset(1);
        chk("rst_mid_cca", rpCCA, 0);
        chk("rst_mid_pip", setPIP, 0);

        // random traffic
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 24) == 0) cmdSEEK = 1;
            if ($urandom_range(0, 29) == 0) cmdSEARCH = 1;
            if ($urandom_range(0, 59) == 0) cmdRECAL = 1;
            if ($urandom_range(0, 199) == 0) clr = 1;
            if (rpCD && $urandom_range(0, 149) == 0) rpCD = 0;
            else if (!rpCD && $urandom_range(0, 4) == 0) rpCD = 1;
            rpDCA = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(800, 1023))
                                                : 10'($urandom_range(0, 12));
            rpDSA = 5'($urandom_range(0, 23));
            rst = ($urandom_range(0, 599) != 0);
            step();
        end
        rst = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
